// File: rtl/mash11_decimator.sv
`timescale 1ns/1ps
// mash11_decimator
// Reconstructs the unsigned WIDTH-bit sample from a MASH 1-1 symbol stream
// using a 2nd-order CIC (sinc^2) decimator by R = 2^LOG2_R, then scales and
// saturates the comb output into the unsigned output range.
//
// Ports:
//   aclk, arst_n                 clock, synchronous active-low reset
//   s_axis_data_t{data,valid}    signed modulator symbol stream (DAC_BW bits)
//   s_axis_data_tready           1 whenever out of reset; input is never stalled
//   m_axis_data_t{data,valid}    reconstructed sample stream (WIDTH bits)
//   m_axis_data_tready           downstream accept
//   overrun                      sticky: an unaccepted sample was overwritten
//   sat                          current m_axis_data_tdata was clamped
module mash11_decimator #(
  parameter int WIDTH  = 16,
  parameter int DAC_BW = 4,
  parameter int LOG2_R = 4
) (
  input  logic              aclk,
  input  logic              arst_n,
  input  logic [DAC_BW-1:0] s_axis_data_tdata,
  input  logic              s_axis_data_tvalid,
  output logic              s_axis_data_tready,
  output logic [WIDTH-1:0]  m_axis_data_tdata,
  output logic              m_axis_data_tvalid,
  input  logic              m_axis_data_tready,
  output logic              overrun,
  output logic              sat
);

  localparam int ACC_W = DAC_BW + 2 * LOG2_R;
  localparam int SHIFT = WIDTH - 2 * LOG2_R;
  localparam int Y_W   = ACC_W + SHIFT;

  localparam logic [LOG2_R-1:0]     CNT_LAST  = {LOG2_R{1'b1}};
  localparam logic [LOG2_R-1:0]     CNT_ONE   = {{(LOG2_R-1){1'b0}}, 1'b1};
  localparam logic [1:0]            WARM_DONE = 2'd2;
  localparam logic signed [Y_W-1:0] Y_MAX     = Y_W'({WIDTH{1'b1}});

  logic                     beat_s;
  logic signed [ACC_W-1:0]  x_s;
  logic signed [ACC_W-1:0]  i1_r, i2_r;
  logic [LOG2_R-1:0]        cnt_r;
  logic                     strobe_r;
  logic signed [ACC_W-1:0]  s_r, s_d_r, c1_d_r, c2_r;
  logic signed [ACC_W-1:0]  c1_s, c2_s;
  logic                     comb_vld_r;
  logic [1:0]               warm_r;
  logic                     emit_s;
  logic signed [Y_W-1:0]    c2_ext_s, y_s;
  logic [WIDTH-1:0]         y_clamp_s;
  logic                     y_sat_s;
  logic [WIDTH-1:0]         tdata_r;
  logic                     tvalid_r, overrun_r, sat_r;

  // The input is never back-pressured, so ready simply follows reset.
  assign beat_s = s_axis_data_tvalid && arst_n;
  assign x_s    = ACC_W'(signed'(s_axis_data_tdata));

  // Integrators and decimation phase counter; everything wraps modulo 2^ACC_W.
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      i1_r     <= {ACC_W{1'b0}};
      i2_r     <= {ACC_W{1'b0}};
      cnt_r    <= {LOG2_R{1'b0}};
      strobe_r <= 1'b0;
      s_r      <= {ACC_W{1'b0}};
    end else begin
      strobe_r <= beat_s && (cnt_r == CNT_LAST);
      if (beat_s) begin
        i1_r  <= i1_r + x_s;
        i2_r  <= i2_r + i1_r;
        cnt_r <= cnt_r + CNT_ONE;
        // Capture the post-update I2 value (old I2 + old I1) on the R-th beat.
        if (cnt_r == CNT_LAST) begin
          s_r <= i2_r + i1_r;
        end else begin
          s_r <= s_r;
        end
      end else begin
        i1_r  <= i1_r;
        i2_r  <= i2_r;
        cnt_r <= cnt_r;
        s_r   <= s_r;
      end
    end
  end

  // Two cascaded differentiators at the decimated rate.
  always_comb begin
    c1_s = s_r - s_d_r;
    c2_s = c1_s - c1_d_r;
  end

  // Comb delay registers and comb result, advanced once per decimation strobe.
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      s_d_r      <= {ACC_W{1'b0}};
      c1_d_r     <= {ACC_W{1'b0}};
      c2_r       <= {ACC_W{1'b0}};
      comb_vld_r <= 1'b0;
    end else if (strobe_r) begin
      s_d_r      <= s_r;
      c1_d_r     <= c1_s;
      c2_r       <= c2_s;
      comb_vld_r <= 1'b1;
    end else begin
      comb_vld_r <= 1'b0;
    end
  end

  // Warm-up counter: the first two comb results still contain start-up transients.
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      warm_r <= 2'd0;
    end else if (comb_vld_r && (warm_r != WARM_DONE)) begin
      warm_r <= warm_r + 2'd1;
    end else begin
      warm_r <= warm_r;
    end
  end

  assign emit_s = comb_vld_r && (warm_r == WARM_DONE);

  // Scale the comb output to WIDTH bits and clamp into the unsigned range.
  always_comb begin
    c2_ext_s  = Y_W'(c2_r);
    y_s       = c2_ext_s <<< SHIFT;
    y_clamp_s = y_s[WIDTH-1:0];
    y_sat_s   = 1'b0;
    if (y_s[Y_W-1]) begin
      y_clamp_s = {WIDTH{1'b0}};
      y_sat_s   = 1'b1;
    end else if (y_s > Y_MAX) begin
      y_clamp_s = {WIDTH{1'b1}};
      y_sat_s   = 1'b1;
    end else begin
      y_clamp_s = y_s[WIDTH-1:0];
      y_sat_s   = 1'b0;
    end
  end

  // Output register with handshake; a load over an unaccepted sample flags overrun.
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      tdata_r   <= {WIDTH{1'b0}};
      sat_r     <= 1'b0;
      tvalid_r  <= 1'b0;
      overrun_r <= 1'b0;
    end else if (emit_s) begin
      tdata_r   <= y_clamp_s;
      sat_r     <= y_sat_s;
      tvalid_r  <= 1'b1;
      overrun_r <= overrun_r || (tvalid_r && !m_axis_data_tready);
    end else if (tvalid_r && m_axis_data_tready) begin
      tvalid_r  <= 1'b0;
    end else begin
      tvalid_r  <= tvalid_r;
    end
  end

  // Outputs read as zero for the whole cycle in which reset is asserted.
  assign s_axis_data_tready = arst_n;
  assign m_axis_data_tdata  = arst_n ? tdata_r : {WIDTH{1'b0}};
  assign m_axis_data_tvalid = tvalid_r && arst_n;
  assign overrun            = overrun_r && arst_n;
  assign sat                = sat_r && arst_n;

endmodule

// File: tb/tb_mash11_decimator.sv
`timescale 1ns/1ps
// Bench for mash11_decimator: table-driven pattern checks, randomized stream
// checked cycle by cycle against a sinc^2 reference model, and hand-written
// overrun and mid-period reset sequences.
module tb_mash11_decimator;
  localparam int WIDTH  = 16;
  localparam int DAC_BW = 4;
  localparam int LOG2_R = 4;
  localparam int R      = 16;
  localparam int SCALE  = 256;  // 2^(WIDTH - 2*LOG2_R)
  localparam int MAXCYC = 8192;

  logic              aclk = 1'b0;
  logic              arst_n;
  logic [DAC_BW-1:0] s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic [WIDTH-1:0]  m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              overrun;
  logic              sat;

  always #5 aclk = ~aclk;

  mash11_decimator #(.WIDTH(WIDTH), .DAC_BW(DAC_BW), .LOG2_R(LOG2_R)) dut (
    .aclk               (aclk),
    .arst_n             (arst_n),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .m_axis_data_tdata  (m_tdata),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tready (m_tready),
    .overrun            (overrun),
    .sat                (sat)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;
  int beats_total = 0;
  int cnt_at [0:MAXCYC-1];

  // reference model state
  int hist[$];
  typedef struct { int due; logic [WIDTH-1:0] d; logic s; } pend_t;
  pend_t pend[$];
  logic             mv, ms, mov;
  logic [WIDTH-1:0] md;

  typedef struct { logic [WIDTH-1:0] d; logic s; int beats; } got_t;
  got_t got[$];

  typedef struct { int len; int sym[4]; logic [WIDTH-1:0] exp_d; logic exp_s; } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cycle, act, exp);
    end
  endtask

  // second integral of the input history after n beats
  function automatic int s_of(int n);
    int acc = 0;
    for (int j = 0; j < n; j++) acc += (n - 1 - j) * hist[j];
    return acc;
  endfunction

  function automatic void model_reset();
    hist.delete();
    pend.delete();
    mv = 1'b0; ms = 1'b0; mov = 1'b0; md = '0;
    beats_total = 0;
  endfunction

  function automatic void model_decim(int cyc);
    int n, c2, y;
    pend_t p;
    n  = hist.size();
    c2 = s_of(n) - 2 * s_of(n - R) + s_of(n - 2 * R);
    y  = c2 * SCALE;
    p.due = cyc + 2;
    if (y < 0) begin p.d = '0; p.s = 1'b1; end
    else if (y > 65535) begin p.d = 16'hFFFF; p.s = 1'b1; end
    else begin p.d = 16'(y); p.s = 1'b0; end
    pend.push_back(p);
  endfunction

  task automatic tick();
    logic beat, rst_now, rdy;
    int   sym;
    #4;
    if (arst_n && m_tvalid && m_tready) begin
      got_t g;
      g.d = m_tdata; g.s = sat;
      g.beats = (cycle >= 2) ? cnt_at[cycle - 2] : -1;
      got.push_back(g);
    end
    beat    = s_tvalid && arst_n;
    rst_now = !arst_n;
    rdy     = m_tready;
    sym     = int'($signed(s_tdata));
    @(posedge aclk);
    #1;
    cycle++;
    if (rst_now) begin
      model_reset();
    end else begin
      if (pend.size() > 0 && pend[0].due == cycle) begin
        if (mv && !rdy) mov = 1'b1;
        md = pend[0].d; ms = pend[0].s; mv = 1'b1;
        void'(pend.pop_front());
      end else if (mv && rdy) begin
        mv = 1'b0;
      end
      if (beat) begin
        hist.push_back(sym);
        beats_total++;
        if (hist.size() % R == 0 && hist.size() / R >= 3) model_decim(cycle);
      end
    end
    if (cycle < MAXCYC) cnt_at[cycle] = beats_total;
    check("outputs{rdy,vld,ovr,sat,data}",
          {12'd0, s_tready, m_tvalid, overrun, sat, m_tdata},
          {12'd0, arst_n, mv, mov, ms, md});
  endtask

  task automatic do_reset(input int n);
    arst_n = 1'b0;
    #1;
    check("in_reset_outputs", {12'd0, s_tready, m_tvalid, overrun, sat, m_tdata}, 32'd0);
    for (int i = 0; i < n; i++) tick();
    arst_n = 1'b1;
    got.delete();
  endtask

  task automatic drive_beat(input int v);
    s_tvalid = 1'b1;
    s_tdata  = 4'(v);
    tick();
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    model_reset();
    arst_n = 1'b0; s_tvalid = 1'b0; s_tdata = 4'd0; m_tready = 1'b1;

    tbl[0] = '{1, '{ 1, 0, 0, 0}, 16'd65535, 1'b1};
    tbl[1] = '{2, '{ 1, 0, 0, 0}, 16'd32768, 1'b0};
    tbl[2] = '{4, '{ 1, 0, 0, 0}, 16'd16384, 1'b0};
    tbl[3] = '{1, '{ 0, 0, 0, 0}, 16'd0,     1'b0};
    tbl[4] = '{1, '{-1, 0, 0, 0}, 16'd0,     1'b1};
    tbl[5] = '{1, '{ 2, 0, 0, 0}, 16'd65535, 1'b1};

    // table-driven patterns, tvalid every cycle, tready high
    for (int t = 0; t < 6; t++) begin
      do_reset(2);
      for (int b = 0; b < 32; b++) drive_beat(tbl[t].sym[b % tbl[t].len]);
      idle(3);
      check($sformatf("warmup_count[%0d]", t), got.size(), 0);
      for (int b = 32; b < 80; b++) drive_beat(tbl[t].sym[b % tbl[t].len]);
      idle(3);
      check($sformatf("n_out[%0d]", t), got.size(), 3);
      foreach (got[k]) begin
        check($sformatf("data[%0d][%0d]", t, k), got[k].d, tbl[t].exp_d);
        check($sformatf("sat[%0d][%0d]", t, k), got[k].s, tbl[t].exp_s);
        check($sformatf("src_beat[%0d][%0d]", t, k), got[k].beats, 16 * (k + 3));
      end
    end

    // 1,0 pattern with tvalid toggling randomly; spacing counted in beats
    begin
      int budget = 0;
      do_reset(1);
      while (got.size() < 6 && budget < 3000) begin
        s_tvalid = 1'($urandom_range(0, 1));
        s_tdata  = (beats_total % 2 == 0) ? 4'd1 : 4'd0;
        tick();
        budget++;
      end
      s_tvalid = 1'b0;
      check("toggle_within_budget", {31'd0, budget < 3000}, 32'd1);
      foreach (got[k]) begin
        check($sformatf("toggle_data[%0d]", k), got[k].d, 16'd32768);
        check($sformatf("toggle_sat[%0d]", k), got[k].s, 1'b0);
        check($sformatf("toggle_beat[%0d]", k), got[k].beats, 16 * (k + 3));
      end
    end

    // random symbols -1..2, random tvalid and tready, model checks every cycle
    do_reset(1);
    for (int i = 0; i < 1500; i++) begin
      s_tvalid = ($urandom_range(0, 3) != 0);
      s_tdata  = 4'(int'($urandom_range(0, 3)) - 1);
      m_tready = ($urandom_range(0, 3) != 0);
      tick();
    end
    m_tready = 1'b1;
    idle(3);

    // overrun: tready low across two decimation periods
    do_reset(1);
    m_tready = 1'b0;
    for (int b = 0; b < 48; b++) drive_beat(b % 2 == 0 ? 1 : 0);
    idle(3);
    check("ovr_first_valid", m_tvalid, 1'b1);
    check("ovr_first_data", m_tdata, 16'd32768);
    check("ovr_not_yet", overrun, 1'b0);
    idle(5);
    check("ovr_held_valid", m_tvalid, 1'b1);
    check("ovr_held_data", m_tdata, 16'd32768);
    for (int b = 48; b < 64; b++) drive_beat(b % 2 == 0 ? 1 : 0);
    idle(3);
    check("ovr_set", overrun, 1'b1);
    check("ovr_second_valid", m_tvalid, 1'b1);
    m_tready = 1'b1;
    idle(3);
    check("ovr_drained", m_tvalid, 1'b0);
    check("ovr_sticky", overrun, 1'b1);
    do_reset(1);
    idle(1);
    check("ovr_cleared", overrun, 1'b0);

    // reset at beat 7 of a period, then 48 further beats to the next sample
    for (int b = 0; b < 55; b++) drive_beat(b % 2 == 0 ? 1 : 0);
    s_tvalid = 1'b0;
    do_reset(1);
    for (int b = 0; b < 47; b++) drive_beat(b % 2 == 0 ? 1 : 0);
    idle(4);
    check("rst_mid_none", got.size(), 0);
    drive_beat(0);
    idle(4);
    check("rst_mid_one", got.size(), 1);
    if (got.size() > 0) begin
      check("rst_mid_data", got[0].d, 16'd32768);
      check("rst_mid_sat", got[0].s, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mash11_decimator.md
Name: mash11_decimator

Overview:
- Receive-side companion to the MASH 1-1 modulator: consumes the signed multi-level modulator stream and reconstructs the unsigned WIDTH-bit sample.
- Uses a 2nd-order CIC (sinc^2) decimator by R = 2^LOG2_R, followed by scaling and saturation.
- Used in loopback verification and as the reference demodulator for on-chip DAC self-test; sits directly on the modulator's master AXI-Stream.

Parameters:
- WIDTH, 16, reconstructed sample width; must equal the modulator's WIDTH.
- DAC_BW, 4, signed input symbol width; valid symbols are -1..+2.
- LOG2_R, 4, log2 of decimation ratio; legal range 2 <= LOG2_R, 2*LOG2_R <= WIDTH.

Ports:
- aclk  input  1  clock
- arst_n  input  1  reset, synchronous, active-low
- s_axis_data_tdata  input  DAC_BW  signed modulator symbol
- s_axis_data_tvalid  input  1  symbol valid
- s_axis_data_tready  output  1  symbol accept
- m_axis_data_tdata  output  WIDTH  unsigned reconstructed sample
- m_axis_data_tvalid  output  1  sample valid
- m_axis_data_tready  input  1  downstream accept
- overrun  output  1  sticky: an unaccepted sample was overwritten
- sat  output  1  current m_axis_data_tdata was clamped

Behaviour:
- Reset: arst_n is synchronous, active-low; clock is aclk. All state clears to 0. Outputs during reset: s_axis_data_tready=0, m_axis_data_tvalid=0, m_axis_data_tdata=0, overrun=0, sat=0. s_axis_data_tready=1 in every cycle after reset is released.
- Beat: s_axis_data_tvalid && s_axis_data_tready. Only beats advance state. Idle cycles hold all state.
- Internal width ACC_W = DAC_BW + 2*LOG2_R, signed two's complement. Integrators and combs wrap modulo 2^ACC_W; no saturation inside the CIC.
- Integrators on each beat, with x sign-extended:
  - I1 <= I1 + x
  - I2 <= I2 + I1, using the old I1
- Phase counter cnt, 0..R-1:
  - increments on each beat and wraps to 0.
  - On the beat where cnt==R-1, a decimation strobe is registered and the updated I2 value is captured as s.
- Comb stage, in the cycle after the strobe:
  - c1 = s - s_d; c2 = c1 - c1_d
  - update s_d <= s, c1_d <= c1
  - register c2.
- Output stage, in the following cycle:
  - y = c2 << (WIDTH - 2*LOG2_R).
  - Clamp: y<0 gives 0; y>2^WIDTH-1 gives 2^WIDTH-1; sat=1 iff clamped.
  - Load m_axis_data_tdata and sat, and set m_axis_data_tvalid=1.
- Latency: m_axis_data_tvalid rises 2 cycles after the cycle in which the R-th beat is accepted.
- Warm-up: the first 2 decimated results after reset are computed but discarded (no tvalid). The first emitted sample comes from the 3rd decimation period.
- Steady state: for an input of period P with R mod P == 0, c2 = R * (sum of the R inputs in one period). Constant input v gives c2 = v*R^2.
- Output handshake:
  - tvalid holds until tready is sampled high, then drops the next cycle unless a new result loads in that same cycle.
  - If a new result loads while tvalid && !tready, the register is overwritten and overrun sets. overrun stays set until reset.
  - Result load coinciding with acceptance: the new result is loaded, tvalid stays 1, overrun is not set.
- Input symbols outside -1..+2 are processed arithmetically without checking.
- Reset mid-period clears cnt, integrators, combs, warm-up count and the output register. The first emitted sample after reset is again from the 3rd full period.
- Throughput: accepts one beat per cycle indefinitely; the output pipeline never back-pressures the input.

Test Plan (WIDTH=16, DAC_BW=4, LOG2_R=4, R=16):
- Constant +1 symbols, tvalid every cycle, tready=1:
  - no tvalid for the first 32 beats
  - 3rd and later outputs 65535 with sat=1 (c2=256)
  - tvalid is 1 cycle wide and arrives 2 cycles after each 16th beat.
- Repeating 1,0 pattern -> every emitted sample is 32768, sat=0. Repeating 1,0,0,0 pattern -> 16384.
- Constant 0 gives 0 with sat=0. Constant -1 gives 0 with sat=1. Constant +2 gives 65535 with sat=1.
- Pattern 1,0 with tvalid toggling randomly at 50% -> same 32768 values. Output spacing equals 16 accepted beats, not cycles.
- tready held 0 across two decimation periods:
  - first sample held stable
  - second overwrites it and overrun=1
  - overrun stays 1 after tready returns, and clears only on arst_n=0.
- Assert arst_n=0 for 1 cycle at beat 7 of a period -> all outputs 0 that cycle. Next emitted sample follows 48 further beats and equals the steady value.
